conv_tile_postproc: RTL and testbench



---
 rtl/conv_tile_postproc.sv | 141 ++++++++++++++
 tb/tb_conv_tile_postproc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_postproc.sv
// Bias, saturate and optionally ReLU a captured Piy x Pix tile, then stream it out row-major.
// Latency: capture in cycle N, first beat valid in cycle N+1, one beat per cycle.
// Backpressure: out_ready stalls the drain with outputs held; a tile arriving while busy is dropped and flagged.
module conv_tile_postproc #(
    parameter int Pix = 3,
    parameter int Piy = 3,
    parameter int RES = 8,
    parameter int IW  = (Piy > 1) ? $clog2(Piy) : 1,
    parameter int JW  = (Pix > 1) ? $clog2(Pix) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [0:Piy-1][0:Pix-1][RES-1:0]      tile_in,
    input  logic                                  tile_valid,
    output logic                                  tile_ready,
    input  logic [RES-1:0]                        bias,
    input  logic                                  bias_load,
    input  logic                                  relu_en,
    input  logic                                  ovf_clr,
    output logic [RES-1:0]                        out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [IW-1:0]                         out_row,
    output logic [JW-1:0]                         out_col,
    output logic                                  out_last,
    output logic                                  overflow
);

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [IW-1:0] LAST_ROW = IW'(Piy - 1);
    localparam logic [JW-1:0] LAST_COL = JW'(Pix - 1);

    state_t         state, state_nx;
    logic [IW-1:0]  row, row_nx;
    logic [JW-1:0]  col, col_nx;
    logic [RES-1:0] bias_reg;
    logic [RES-1:0] tile_buf [Piy][Pix];
    logic           capture;
    logic           drop;
    logic           at_last;

    // Signed add of one element and the bias with clamping, then optional ReLU.
    function automatic logic [RES-1:0] post(input logic [RES-1:0] a,
                                            input logic [RES-1:0] b,
                                            input logic           relu);
        logic signed [RES:0] s;
        logic [RES-1:0]      r;
        s = $signed({a[RES-1], a}) + $signed({b[RES-1], b});
        if (s[RES] != s[RES-1])
            r = s[RES] ? {1'b1, {(RES-1){1'b0}}} : {1'b0, {(RES-1){1'b1}}};
        else
            r = s[RES-1:0];
        if (relu && r[RES-1])
            r = '0;
        return r;
    endfunction

    assign at_last    = (state == DRAIN) && (row == LAST_ROW) && (col == LAST_COL);
    assign out_valid  = (state == DRAIN);
    assign out_last   = at_last;
    assign out_row    = row;
    assign out_col    = col;
    assign out_data   = out_valid ? tile_buf[row][col] : '0;
    // Ready in the final handshake cycle lets the next tile follow with no bubble.
    assign tile_ready = (state == IDLE) || (out_valid && out_ready && at_last);
    assign capture    = tile_valid && tile_ready;
    assign drop       = tile_valid && !tile_ready;

    // Next state and drain position.
    always_comb begin
        state_nx = state;
        row_nx   = row;
        col_nx   = col;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nx = DRAIN;
                    row_nx   = '0;
                    col_nx   = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (at_last) begin
                        row_nx   = '0;
                        col_nx   = '0;
                        state_nx = capture ? DRAIN : IDLE;
                    end else if (col == LAST_COL) begin
                        col_nx = '0;
                        row_nx = row + 1'b1;
                    end else begin
                        col_nx = col + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and position registers; reset aborts any drain in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_nx;
            row   <= row_nx;
            col   <= col_nx;
        end
    end

    // Bias register; a same-cycle capture still sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bias_reg <= '0;
        else if (bias_load)
            bias_reg <= bias;
    end

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

    // Processed tile storage, written whole on capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < Piy; i++)
                for (int j = 0; j < Pix; j++)
                    tile_buf[i][j] <= post(tile_in[i][j], bias_reg, relu_en);
        end
    end

endmodule

// File: tb/tb_conv_tile_postproc.sv
// Randomised and directed bench for conv_tile_postproc against a queue-based reference.
// Latency: checks each cycle shortly after the falling edge.
// Backpressure: exercises stalls, back-to-back tiles, drops and reset mid-drain.
module tb_conv_tile_postproc;

    typedef logic [0:2][0:2][7:0] tile_t;
    typedef struct {
        int d;
        int r;
        int c;
        bit last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    tile_t       tile_in = '0;
    logic        tile_valid = 1'b0;
    logic        tile_ready;
    logic [7:0]  bias = '0;
    logic        bias_load = 1'b0;
    logic        relu_en = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        overflow;

    int    total = 0;
    int    bad   = 0;
    beat_t q[$];
    int    bias_m = 0;
    bit    ovf_m  = 0;

    conv_tile_postproc #(.Pix(3), .Piy(3), .RES(8)) dut (
        .clk(clk), .rst(rst), .tile_in(tile_in), .tile_valid(tile_valid),
        .tile_ready(tile_ready), .bias(bias), .bias_load(bias_load),
        .relu_en(relu_en), .ovf_clr(ovf_clr), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_col(out_col), .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic tile_t mk(input int v[9]);
        tile_t t;
        for (int k = 0; k < 9; k++)
            t[k/3][k%3] = 8'(v[k]);
        return t;
    endfunction

    function automatic tile_t rnd_tile();
        tile_t t;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                t[r][c] = 8'($urandom);
        return t;
    endfunction

    // Enqueue the nine beats the rules say this tile must produce.
    task automatic model_push(input tile_t t, input bit relu);
        beat_t b;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                int v;
                v = int'($signed(t[r][c])) + bias_m;
                if (v > 127)  v = 127;
                if (v < -128) v = -128;
                if (relu && v < 0) v = 0;
                b.d = v; b.r = r; b.c = c; b.last = (r == 2 && c == 2);
                q.push_back(b);
            end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit tv, input tile_t t, input bit bl, input logic [7:0] b,
                        input bit relu, input bit clr, input bit ordy);
        bit exp_rdy;
        bit hs;
        @(negedge clk);
        tile_valid = tv; tile_in = t; bias_load = bl; bias = b;
        relu_en = relu; ovf_clr = clr; out_ready = ordy;
        #1;
        chk("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
        if (q.size() != 0) begin
            chk("out_data", int'($signed(out_data)), q[0].d);
            chk("out_row",  int'(out_row),  q[0].r);
            chk("out_col",  int'(out_col),  q[0].c);
            chk("out_last", int'(out_last), int'(q[0].last));
        end
        exp_rdy = (q.size() == 0) || (ordy && q.size() == 1);
        chk("tile_ready", int'(tile_ready), int'(exp_rdy));
        chk("overflow", int'(overflow), int'(ovf_m));
        hs = (q.size() != 0) && ordy;
        if (hs) void'(q.pop_front());
        if (tv && exp_rdy) model_push(t, relu);
        if (tv && !exp_rdy) ovf_m = 1;
        else if (clr) ovf_m = 0;
        if (bl) bias_m = int'($signed(b));
    endtask

    task automatic idle_step(input bit ordy);
        step(1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0, ordy);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            idle_step(1'b1);
            n++;
        end
        chk("drain_done", q.size(), 0);
    endtask

    int    vals[9];
    tile_t ta;
    tile_t tb;
    int    pat[6];

    initial begin
        // Reset state
        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data",  int'(out_data), 0);
        chk("rst_row",   int'(out_row), 0);
        chk("rst_col",   int'(out_col), 0);
        chk("rst_last",  int'(out_last), 0);
        chk("rst_ovf",   int'(overflow), 0);
        chk("rst_ready", int'(tile_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Plain tile 1..9 with ReLU, zero bias
        vals = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        ta = mk(vals);
        step(1'b1, ta, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();
        idle_step(1'b1);

        // Saturation and ReLU with two bias values
        for (int relu = 0; relu < 2; relu++) begin
            step(1'b0, '0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b1);
            vals = '{120, -128, -5, 0, 1, -1, 117, 118, 60};
            ta = mk(vals);
            step(1'b1, ta, 1'b0, 8'h00, relu[0], 1'b0, 1'b1);
            drain();
            step(1'b0, '0, 1'b1, 8'(-30), 1'b0, 1'b0, 1'b1);
            vals = '{100, -100, -98, -99, 127, -128, 30, 29, 0};
            ta = mk(vals);
            step(1'b1, ta, 1'b0, 8'h00, relu[0], 1'b0, 1'b1);
            drain();
        end

        // Bias load in the capture cycle must not affect that tile
        ta = rnd_tile();
        step(1'b1, ta, 1'b1, 8'd50, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure pattern
        pat = '{1, 0, 0, 1, 0, 1};
        ta = rnd_tile();
        step(1'b1, ta, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60 && q.size() != 0; i++)
            idle_step(pat[i % 6][0]);
        chk("bp_done", q.size(), 0);

        // Back-to-back tiles with no bubble
        ta = rnd_tile();
        tb = rnd_tile();
        step(1'b1, ta, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && q.size() != 1; i++)
            idle_step(1'b1);
        step(1'b1, tb, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("b2b_qlen", q.size(), 9);
        drain();

        // Drop while busy, clear, then clear colliding with another drop
        ta = rnd_tile();
        step(1'b1, ta, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle_step(1'b1);
        idle_step(1'b1);
        step(1'b1, rnd_tile(), 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();
        idle_step(1'b1);
        step(1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        idle_step(1'b1);
        ta = rnd_tile();
        step(1'b1, ta, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, rnd_tile(), 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        drain();
        idle_step(1'b1);
        chk("ovf_sticky", int'(overflow), 1);

        // Reset after four handshaked beats
        step(1'b0, '0, 1'b1, 8'd20, 1'b0, 1'b0, 1'b1);
        ta = rnd_tile();
        step(1'b1, ta, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            idle_step(1'b1);
        @(negedge clk);
        tile_valid = 1'b0; bias_load = 1'b0; ovf_clr = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_ready", int'(tile_ready), 1);
        chk("mid_rst_ovf",   int'(overflow), 0);
        q.delete();
        bias_m = 0;
        ovf_m  = 0;
        @(negedge clk);
        rst = 1'b0;
        ta = rnd_tile();
        step(1'b1, ta, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 5) == 0), rnd_tile(), ($urandom_range(0, 9) == 0),
                 8'($urandom), $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) < 7));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
